bit_serial_adder: RTL



---
 rtl/bit_serial_adder_pkg.sv | 13 +
 rtl/bit_serial_adder_fa_cell.sv | 17 +
 rtl/bit_serial_adder.sv | 119 +++++++++++
 3 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package bit_serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage : bit_serial_adder_pkg

// File: rtl/bit_serial_adder_fa_cell.sv
// One-bit full adder. Purely combinational; the serial adder feeds it one
// operand bit pair plus the stored carry each clock.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic c
);

   // Sum and majority carry; the carry is built from cin, never from s or c.
   always_comb begin
      s = a ^ b ^ cin;
      c = (a & b) | (b & cin) | (cin & a);
   end

endmodule : fa_cell

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first through a single
// full-adder cell, keeping the carry in a flip-flop between bits and
// collecting sum bits in a right-shifting register.
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             cout_q;
   logic             fa_s;
   logic             fa_c;
   logic             last_bit;

   fa_cell u_fa_cell (
      .a   (op_a_q[0]),
      .b   (op_b_q[0]),
      .cin (carry_q),
      .s   (fa_s),
      .c   (fa_c)
   );

   assign last_bit = (cnt_q == LAST_BIT);

   // State register; reset abandons any add in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of block ordering.
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
   always_comb begin
      // NOTE: default assigned first so no path leaves state_d unassigned
      // (which would infer a latch).
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: operand capture on accept, one bit per edge in RUN, and the
   // result registers updated only on the final bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_q  <= '0;
         op_b_q  <= '0;
         shift_q <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_a_q  <= a;
                  op_b_q  <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               op_a_q  <= op_a_q >> 1;
               op_b_q  <= op_b_q >> 1;
               shift_q <= {fa_s, shift_q[WIDTH-1:1]};
               carry_q <= fa_c;
               if (last_bit) begin
                  sum_q  <= {fa_s, shift_q[WIDTH-1:1]};
                  cout_q <= fa_c;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Status decoded straight from the state register so reset clears it
   // without waiting for a clock.
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule : bit_serial_adder
